md_sched: RTL and testbench

Multiply/divide scheduler for the five-stage pipeline: sequences the shared HI/LO multiply-divide unit. Turns E-stage MD instructions into a single-cycle start pulse and a forwarded operation code, and models the unit's fixed latency with a down-counter. It also drives the D-stage stall for any MD-class instruction that would use the unit while it is starting or busy. Sits between the hazard unit and the MD datapath; it is the sole owner of the datapath's start/busy timing.

---
 rtl/md_pkg.sv | 34 +++
 rtl/md_lat_counter.sv | 37 +++
 rtl/md_sched.sv | 72 +++++++
 tb/tb_md_sched.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared op-codes, default latencies and op-class helpers for the MD scheduler.
`default_nettype none
package md_pkg;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MFHI  = 4'd4;
  localparam logic [3:0] OP_MFLO  = 4'd5;
  localparam logic [3:0] OP_MTHI  = 4'd6;
  localparam logic [3:0] OP_MTLO  = 4'd7;
  localparam logic [3:0] OP_NONE  = 4'd15;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Ops that occupy the unit for a multi-cycle computation.
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op <= OP_DIVU);
  endfunction

  // Any op touching HI/LO, including the single-cycle moves.
  function automatic logic is_md(input logic [3:0] op);
    return (op <= OP_MTLO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_lat_counter.sv
// md_lat_counter: loadable down-counter with a last-cycle flag (count==1).
`default_nettype none
module md_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             cnt_en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             last_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = load_val_i;
    else if (cnt_en_i && (count_q != '0))
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count_o = count_q;
  assign last_o  = (count_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/md_sched.sv
// md_sched: sequences the shared HI/LO mult/div unit: start pulse, busy timing, D-stage stall.
`default_nettype none
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       d_md_op,
  input  logic             e_valid,
  input  logic [3:0]       e_md_op,
  output logic             md_start,
  output logic [3:0]       md_ctrl,
  output logic             md_busy,
  output logic             commit,
  output logic             stall_d,
  output logic [CNT_W-1:0] cycles_left,
  output logic             proto_err
);

  md_state_e        state_q;
  logic             proto_err_q;
  logic [CNT_W-1:0] lat_val;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic             running;

  assign running  = (state_q == ST_RUN);
  assign md_start = !running && e_valid && is_muldiv(e_md_op);
  assign md_ctrl  = e_valid ? e_md_op : OP_NONE;

  // Bit 1 separates div/divu (2,3) from mult/multu (0,1) once is_muldiv holds.
  assign lat_val = e_md_op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

  md_lat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (reset),
    .load_i    (md_start),
    .load_val_i(lat_val),
    .cnt_en_i  (running),
    .count_o   (cnt),
    .last_o    (cnt_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      proto_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (md_start) state_q <= ST_RUN;
        ST_RUN:  if (cnt_last) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
      if (running && e_valid && is_md(e_md_op))
        proto_err_q <= 1'b1;
    end
  end

  assign md_busy     = running;
  assign commit      = running && cnt_last;
  assign stall_d     = is_md(d_md_op) && (md_start || running);
  assign cycles_left = cnt;
  assign proto_err   = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_md_sched.sv
// tb_md_sched: directed self-checking bench for md_sched.
`default_nettype none
module tb_md_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] d_md_op;
  logic       e_valid;
  logic [3:0] e_md_op;
  logic       md_start;
  logic [3:0] md_ctrl;
  logic       md_busy;
  logic       commit;
  logic       stall_d;
  logic [3:0] cycles_left;
  logic       proto_err;

  int total = 0;
  int bad   = 0;

  md_sched #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .d_md_op(d_md_op), .e_valid(e_valid), .e_md_op(e_md_op),
    .md_start(md_start), .md_ctrl(md_ctrl), .md_busy(md_busy), .commit(commit),
    .stall_d(stall_d), .cycles_left(cycles_left), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Each "cycle" begins at a negedge: inputs change there, outputs are sampled 1ns later.
  task automatic cyc(input logic v, input logic [3:0] eop, input logic [3:0] dop);
    @(negedge clk);
    e_valid = v; e_md_op = eop; d_md_op = dop;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; e_valid = 1'b0; e_md_op = 4'd15; d_md_op = 4'd15;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({md_start, md_busy, commit, stall_d, proto_err} !== 5'b0 || cycles_left !== 4'd0 || md_ctrl !== 4'd15) begin
      bad++;
      $display("FAIL reset: start=%b busy=%b commit=%b stall=%b perr=%b left=%0d ctrl=%0d, need all 0 and ctrl=15",
               md_start, md_busy, commit, stall_d, proto_err, cycles_left, md_ctrl);
    end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_mult;
    cyc(1'b1, 4'd0, 4'd15);
    total++;
    if (md_start !== 1'b1 || md_ctrl !== 4'd0 || md_busy !== 1'b0) begin
      bad++; $display("FAIL mult_start: start=%b ctrl=%0d busy=%b, need 1 0 0", md_start, md_ctrl, md_busy);
    end
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b0, 4'd15, 4'd15);
      total++;
      if (md_busy !== (k <= 5) || commit !== (k == 5) || md_start !== 1'b0 ||
          cycles_left !== ((k <= 5) ? 4'(6 - k) : 4'd0)) begin
        bad++;
        $display("FAIL mult_run k=%0d: busy=%b commit=%b start=%b left=%0d, need %b %b 0 %0d",
                 k, md_busy, commit, md_start, cycles_left, (k <= 5), (k == 5), (k <= 5) ? 6 - k : 0);
      end
    end
  endtask

  task automatic test_div_stall;
    cyc(1'b1, 4'd3, 4'd5);
    total++;
    if (md_start !== 1'b1 || stall_d !== 1'b1) begin
      bad++; $display("FAIL divu_start: start=%b stall=%b, need 1 1", md_start, stall_d);
    end
    for (int k = 1; k <= 11; k++) begin
      cyc(1'b0, 4'd15, 4'd5);
      total++;
      if (stall_d !== (k <= 10) || commit !== (k == 10) || cycles_left !== ((k <= 10) ? 4'(11 - k) : 4'd0)) begin
        bad++;
        $display("FAIL divu_run k=%0d: stall=%b commit=%b left=%0d, need %b %b %0d",
                 k, stall_d, commit, cycles_left, (k <= 10), (k == 10), (k <= 10) ? 11 - k : 0);
      end
      if (k == 3) begin
        d_md_op = 4'd15; #1;
        total++;
        if (stall_d !== 1'b0) begin bad++; $display("FAIL stall_none: stall=%b, need 0", stall_d); end
        d_md_op = 4'd8; #1;
        total++;
        if (stall_d !== 1'b0) begin bad++; $display("FAIL stall_op8: stall=%b, need 0", stall_d); end
        d_md_op = 4'd5;
      end
    end
  endtask

  task automatic test_back_to_back;
    cyc(1'b1, 4'd1, 4'd15);
    for (int k = 1; k <= 5; k++) cyc(1'b0, 4'd15, 4'd15);
    // Cycle T+LAT+1: the unit is idle again, so mfhi reads cleanly and a new mult may start.
    cyc(1'b1, 4'd4, 4'd15);
    total++;
    if (md_start !== 1'b0 || md_ctrl !== 4'd4 || md_busy !== 1'b0) begin
      bad++; $display("FAIL mfhi_after: start=%b ctrl=%0d busy=%b, need 0 4 0", md_start, md_ctrl, md_busy);
    end
    cyc(1'b1, 4'd0, 4'd15);
    total++;
    if (md_start !== 1'b1 || proto_err !== 1'b0) begin
      bad++; $display("FAIL b2b_start: start=%b perr=%b, need 1 0", md_start, proto_err);
    end
    cyc(1'b0, 4'd15, 4'd15);
    total++;
    if (md_busy !== 1'b1 || cycles_left !== 4'd5) begin
      bad++; $display("FAIL b2b_run: busy=%b left=%0d, need 1 5", md_busy, cycles_left);
    end
    for (int k = 2; k <= 5; k++) cyc(1'b0, 4'd15, 4'd15);
  endtask

  task automatic test_proto;
    cyc(1'b0, 4'd15, 4'd15);
    cyc(1'b1, 4'd0, 4'd15);
    for (int k = 1; k <= 6; k++) begin
      if (k == 2) cyc(1'b1, 4'd6, 4'd15);
      else        cyc(1'b0, 4'd15, 4'd15);
      if (k == 2) begin
        total++;
        if (md_start !== 1'b0 || proto_err !== 1'b0) begin
          bad++; $display("FAIL proto_inject: start=%b perr=%b, need 0 0", md_start, proto_err);
        end
      end
      if (k >= 3) begin
        total++;
        if (proto_err !== 1'b1 || commit !== (k == 5) || cycles_left !== ((k <= 5) ? 4'(6 - k) : 4'd0)) begin
          bad++;
          $display("FAIL proto_run k=%0d: perr=%b commit=%b left=%0d, need 1 %b %0d",
                   k, proto_err, commit, cycles_left, (k == 5), (k <= 5) ? 6 - k : 0);
        end
      end
    end
  endtask

  task automatic test_abort;
    cyc(1'b1, 4'd2, 4'd15);
    cyc(1'b0, 4'd15, 4'd15);
    cyc(1'b0, 4'd15, 4'd15);
    @(negedge clk); reset = 1'b0; #1;
    total++;
    if (md_busy !== 1'b0 || cycles_left !== 4'd0 || commit !== 1'b0 || proto_err !== 1'b0) begin
      bad++; $display("FAIL abort: busy=%b left=%0d commit=%b perr=%b, need 0 0 0 0",
                      md_busy, cycles_left, commit, proto_err);
    end
    cyc(1'b0, 4'd15, 4'd15);
    @(negedge clk); reset = 1'b1;
    for (int k = 6; k <= 11; k++) begin
      cyc(1'b0, 4'd15, 4'd15);
      total++;
      if (commit !== 1'b0 || md_busy !== 1'b0) begin
        bad++; $display("FAIL abort_nocommit k=%0d: commit=%b busy=%b, need 0 0", k, commit, md_busy);
      end
    end
    cyc(1'b1, 4'd0, 4'd15);
    total++;
    if (md_start !== 1'b1) begin bad++; $display("FAIL abort_restart: start=%b, need 1", md_start); end
    cyc(1'b0, 4'd15, 4'd15);
    total++;
    if (md_busy !== 1'b1 || cycles_left !== 4'd5) begin
      bad++; $display("FAIL abort_restart_run: busy=%b left=%0d, need 1 5", md_busy, cycles_left);
    end
    for (int k = 2; k <= 6; k++) cyc(1'b0, 4'd15, 4'd15);
  endtask

  task automatic test_bubble;
    cyc(1'b0, 4'd2, 4'd2);
    total++;
    if (md_start !== 1'b0 || md_ctrl !== 4'd15 || stall_d !== 1'b0) begin
      bad++; $display("FAIL bubble: start=%b ctrl=%0d stall=%b, need 0 15 0", md_start, md_ctrl, stall_d);
    end
    cyc(1'b0, 4'd15, 4'd15);
    total++;
    if (md_busy !== 1'b0 || cycles_left !== 4'd0 || proto_err !== 1'b0) begin
      bad++; $display("FAIL bubble_idle: busy=%b left=%0d perr=%b, need 0 0 0", md_busy, cycles_left, proto_err);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_stall();
    test_back_to_back();
    test_proto();
    test_abort();
    test_bubble();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
